// File: rtl/regfile_2r1w_if.sv
// Port bundle for the 2-read/1-write register file.
// The master side issues writes, reads and clear requests.
// The slave side (the register file) returns read data, strobes and busy.
interface regfile_2r1w_if #(
   parameter int MEM_WIDTH    = 8,
   parameter int ADDRESS_SIZE = 4
);
   // Write port
   logic                    wr_en;
   logic [ADDRESS_SIZE-1:0] wr_addr;
   logic [MEM_WIDTH-1:0]    wr_data;
   logic [MEM_WIDTH-1:0]    wr_mask;
   logic                    wr_err;

   // Read port 0
   logic                    rd0_en;
   logic [ADDRESS_SIZE-1:0] rd0_addr;
   logic [MEM_WIDTH-1:0]    rd0_data;
   logic                    rd0_valid;
   logic                    rd0_err;

   // Read port 1
   logic                    rd1_en;
   logic [ADDRESS_SIZE-1:0] rd1_addr;
   logic [MEM_WIDTH-1:0]    rd1_data;
   logic                    rd1_valid;
   logic                    rd1_err;

   // Clear engine control
   logic                    clear_req;
   logic                    busy;

   modport master (
      output wr_en, wr_addr, wr_data, wr_mask,
      output rd0_en, rd0_addr, rd1_en, rd1_addr,
      output clear_req,
      input  wr_err,
      input  rd0_data, rd0_valid, rd0_err,
      input  rd1_data, rd1_valid, rd1_err,
      input  busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_mask,
      input  rd0_en, rd0_addr, rd1_en, rd1_addr,
      input  clear_req,
      output wr_err,
      output rd0_data, rd0_valid, rd0_err,
      output rd1_data, rd1_valid, rd1_err,
      output busy
   );
endinterface

// File: rtl/regfile_2r1w.sv
// Register file with two read ports and one masked write port.
// Features: registered reads with valid strobes, a write-first bypass,
// out-of-range detection, and a clear engine that walks every entry
// after reset or on request.
module regfile_2r1w #(
   parameter int                   MEM_WIDTH    = 8,
   parameter int                   ADDRESS_SIZE = 4,
   parameter int                   MEM_DEPTH    = 16,
   parameter logic [MEM_WIDTH-1:0] CLEAR_VALUE  = '0
) (
   input  logic          clk,
   input  logic          rst,
   regfile_2r1w_if.slave bus
);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   localparam int NUM_RD = 2;

   // One extra bit so that MEM_DEPTH == 2**ADDRESS_SIZE is representable.
   localparam logic [ADDRESS_SIZE:0]   DEPTH_EXT = (ADDRESS_SIZE+1)'(MEM_DEPTH);
   localparam logic [ADDRESS_SIZE-1:0] LAST_IDX  = ADDRESS_SIZE'(MEM_DEPTH - 1);

   logic [MEM_WIDTH-1:0]    mem_q [MEM_DEPTH];

   logic [0:0]              state_q, state_d;
   logic [ADDRESS_SIZE-1:0] clr_idx_q, clr_idx_d;
   logic                    ready;

   logic                    wr_in_range;
   logic                    wr_fire;
   logic [MEM_WIDTH-1:0]    wr_old;
   logic [MEM_WIDTH-1:0]    wr_merged;
   logic                    wr_err_q, wr_err_d;

   // Read request inputs gathered into vectors so the ports share one generate body.
   logic [NUM_RD-1:0]                   rd_en_w;
   logic [NUM_RD-1:0][ADDRESS_SIZE-1:0] rd_addr_w;

   assign rd_en_w   = {bus.rd1_en,   bus.rd0_en};
   assign rd_addr_w = {bus.rd1_addr, bus.rd0_addr};

   assign ready    = (state_q == ST_READY);
   assign bus.busy = (state_q == ST_CLEAR);

   // Write path: range check and read-modify-write merge under the bit mask.
   assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_EXT);
   assign wr_fire     = ready && bus.wr_en && wr_in_range;
   assign wr_old      = wr_in_range ? mem_q[bus.wr_addr] : '0;
   assign wr_merged   = (wr_old & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);
   assign wr_err_d    = ready && bus.wr_en && !wr_in_range;

   // Clear engine sequencing: walk entries 0..MEM_DEPTH-1 then return to READY.
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      if (state_q == ST_CLEAR) begin
         if (clr_idx_q == LAST_IDX) begin
            state_d   = ST_READY;
            clr_idx_d = '0;
         end else begin
            clr_idx_d = clr_idx_q + ADDRESS_SIZE'(1);
         end
      end else if (bus.clear_req) begin
         state_d   = ST_CLEAR;
         clr_idx_d = '0;
      end
   end

   // State and clear counter registers; reset restarts the clear from entry 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_CLEAR;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   // Memory array update: the clear engine owns the port while busy, otherwise the write port.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == ST_CLEAR) begin
            mem_q[clr_idx_q] <= CLEAR_VALUE;
         end else if (wr_fire) begin
            mem_q[bus.wr_addr] <= wr_merged;
         end
      end
   end

   // Write error strobe register.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_err_q <= 1'b0;
      end else begin
         wr_err_q <= wr_err_d;
      end
   end

   assign bus.wr_err = wr_err_q;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic                 in_range;
         logic                 bypass_hit;
         logic [MEM_WIDTH-1:0] data_q, data_d;
         logic                 valid_q, valid_d;
         logic                 err_q, err_d;

         assign in_range   = ({1'b0, rd_addr_w[gi]} < DEPTH_EXT);
         assign bypass_hit = wr_fire && (rd_addr_w[gi] == bus.wr_addr);

         // Read selection: out-of-range reads return zero, same-address writes are forwarded.
         always_comb begin
            data_d  = data_q;
            valid_d = 1'b0;
            err_d   = 1'b0;
            if (ready && rd_en_w[gi]) begin
               valid_d = 1'b1;
               if (!in_range) begin
                  data_d = '0;
                  err_d  = 1'b1;
               end else if (bypass_hit) begin
                  data_d = wr_merged;
               end else begin
                  data_d = mem_q[rd_addr_w[gi]];
               end
            end
         end

         // Read output registers; data holds when no read is accepted.
         always_ff @(posedge clk) begin
            if (rst) begin
               data_q  <= '0;
               valid_q <= 1'b0;
               err_q   <= 1'b0;
            end else begin
               data_q  <= data_d;
               valid_q <= valid_d;
               err_q   <= err_d;
            end
         end
      end
   endgenerate

   assign bus.rd0_data  = g_rd[0].data_q;
   assign bus.rd0_valid = g_rd[0].valid_q;
   assign bus.rd0_err   = g_rd[0].err_q;
   assign bus.rd1_data  = g_rd[1].data_q;
   assign bus.rd1_valid = g_rd[1].valid_q;
   assign bus.rd1_err   = g_rd[1].err_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: a 16-entry instance (A) and a
// 12-entry instance (B) share clock and reset. Read expectations are
// queued when a read is driven and checked when the strobe is due.
module tb_regfile_2r1w;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   regfile_2r1w_if #(.MEM_WIDTH(8), .ADDRESS_SIZE(4)) ia ();
   regfile_2r1w_if #(.MEM_WIDTH(8), .ADDRESS_SIZE(4)) ib ();

   regfile_2r1w #(.MEM_WIDTH(8), .ADDRESS_SIZE(4), .MEM_DEPTH(16), .CLEAR_VALUE(8'h00))
      dut_a (.clk(clk), .rst(rst), .bus(ia.slave));

   regfile_2r1w #(.MEM_WIDTH(8), .ADDRESS_SIZE(4), .MEM_DEPTH(12), .CLEAR_VALUE(8'h00))
      dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [7:0] data;
      logic       err;
   } exp_t;

   exp_t qa0[$];
   exp_t qa1[$];
   exp_t qb0[$];
   exp_t qb1[$];

   logic exp_wr_err_a = 1'b0;
   logic exp_wr_err_b = 1'b0;

   logic [7:0] ma [16];
   logic [7:0] mb [12];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      chk(tag, {7'b0, obs}, {7'b0, exp});
   endtask

   task automatic idle();
      ia.wr_en = 1'b0; ia.rd0_en = 1'b0; ia.rd1_en = 1'b0; ia.clear_req = 1'b0;
      ib.wr_en = 1'b0; ib.rd0_en = 1'b0; ib.rd1_en = 1'b0; ib.clear_req = 1'b0;
   endtask

   task automatic port_check(input string tag, input logic v, input logic e,
                             input logic [7:0] d, input bit has, input exp_t x);
      if (has) begin
         chk_bit({tag, ".valid"}, v, 1'b1);
         chk({tag, ".data"}, d, x.data);
         chk_bit({tag, ".err"}, e, x.err);
         $display("%0t %s read data=0x%02h err=%0b (want 0x%02h/%0b)", $time, tag, d, e, x.data, x.err);
      end else begin
         chk_bit({tag, ".valid"}, v, 1'b0);
         chk_bit({tag, ".err"}, e, 1'b0);
      end
   endtask

   // One clock edge, then check every strobe against the scoreboard and go idle.
   task automatic tick();
      exp_t x;
      bit   h;
      @(posedge clk);
      #1;
      h = (qa0.size() != 0); x = '0; if (h) x = qa0.pop_front();
      port_check("a.rd0", ia.rd0_valid, ia.rd0_err, ia.rd0_data, h, x);
      h = (qa1.size() != 0); x = '0; if (h) x = qa1.pop_front();
      port_check("a.rd1", ia.rd1_valid, ia.rd1_err, ia.rd1_data, h, x);
      h = (qb0.size() != 0); x = '0; if (h) x = qb0.pop_front();
      port_check("b.rd0", ib.rd0_valid, ib.rd0_err, ib.rd0_data, h, x);
      h = (qb1.size() != 0); x = '0; if (h) x = qb1.pop_front();
      port_check("b.rd1", ib.rd1_valid, ib.rd1_err, ib.rd1_data, h, x);
      chk_bit("a.wr_err", ia.wr_err, exp_wr_err_a);
      chk_bit("b.wr_err", ib.wr_err, exp_wr_err_b);
      exp_wr_err_a = 1'b0;
      exp_wr_err_b = 1'b0;
      idle();
   endtask

   task automatic a_write(input int addr, input logic [7:0] d, input logic [7:0] m, input bit acc);
      ia.wr_en = 1'b1; ia.wr_addr = 4'(addr); ia.wr_data = d; ia.wr_mask = m;
      if (acc) ma[addr] = (ma[addr] & ~m) | (d & m);
      $display("%0t a.wr addr=%0d data=0x%02h mask=0x%02h accepted=%0b", $time, addr, d, m, acc);
   endtask

   task automatic a_read(input int port, input int addr, input bit acc);
      exp_t x;
      x.data = ma[addr];
      x.err  = 1'b0;
      if (port == 0) begin
         ia.rd0_en = 1'b1; ia.rd0_addr = 4'(addr);
         if (acc) qa0.push_back(x);
      end else begin
         ia.rd1_en = 1'b1; ia.rd1_addr = 4'(addr);
         if (acc) qa1.push_back(x);
      end
   endtask

   task automatic b_write(input int addr, input logic [7:0] d, input logic [7:0] m);
      ib.wr_en = 1'b1; ib.wr_addr = 4'(addr); ib.wr_data = d; ib.wr_mask = m;
      if (addr < 12) mb[addr] = (mb[addr] & ~m) | (d & m);
      else exp_wr_err_b = 1'b1;
      $display("%0t b.wr addr=%0d data=0x%02h mask=0x%02h", $time, addr, d, m);
   endtask

   task automatic b_read(input int port, input int addr);
      exp_t x;
      if (addr < 12) begin
         x.data = mb[addr]; x.err = 1'b0;
      end else begin
         x.data = 8'h00;    x.err = 1'b1;
      end
      if (port == 0) begin
         ib.rd0_en = 1'b1; ib.rd0_addr = 4'(addr); qb0.push_back(x);
      end else begin
         ib.rd1_en = 1'b1; ib.rd1_addr = 4'(addr); qb1.push_back(x);
      end
   endtask

   initial begin
      rst = 1'b1;
      ia.wr_addr = '0; ia.wr_data = '0; ia.wr_mask = '0; ia.rd0_addr = '0; ia.rd1_addr = '0;
      ib.wr_addr = '0; ib.wr_data = '0; ib.wr_mask = '0; ib.rd0_addr = '0; ib.rd1_addr = '0;
      idle();
      for (int i = 0; i < 16; i++) ma[i] = 8'h00;
      for (int i = 0; i < 12; i++) mb[i] = 8'h00;

      // Reset held three cycles
      repeat (3) begin
         tick();
         chk_bit("a.busy_rst", ia.busy, 1'b1);
         chk_bit("b.busy_rst", ib.busy, 1'b1);
      end
      chk("a.rd0_data_rst", ia.rd0_data, 8'h00);
      chk("a.rd1_data_rst", ia.rd1_data, 8'h00);
      chk("b.rd0_data_rst", ib.rd0_data, 8'h00);
      rst = 1'b0;

      // Clear after reset; a request mid-clear must be ignored
      for (int k = 1; k <= 16; k++) begin
         chk_bit("a.busy_clr", ia.busy, 1'b1);
         chk_bit("b.busy_clr", ib.busy, (k <= 12));
         if (k == 5) begin
            a_write(1, 8'hEE, 8'hFF, 1'b0);
            a_read(0, 1, 1'b0);
         end
         tick();
      end
      chk_bit("a.busy_done", ia.busy, 1'b0);
      chk_bit("b.busy_done", ib.busy, 1'b0);

      // First reads after clear
      a_read(0, 0, 1'b1);
      a_read(1, 15, 1'b1);
      tick();
      a_read(0, 1, 1'b1);
      tick();

      // Masked write then dual read of the same address
      a_write(3, 8'hA5, 8'hFF, 1'b1);
      tick();
      a_write(3, 8'h0F, 8'hF0, 1'b1);
      tick();
      a_read(0, 3, 1'b1);
      a_read(1, 3, 1'b1);
      tick();
      chk("a.rd0_masked", ia.rd0_data, 8'h05);
      chk("a.rd1_masked", ia.rd1_data, 8'h05);

      // Write-first bypass, full and partial mask
      a_write(6, 8'h3C, 8'hFF, 1'b1);
      a_read(0, 6, 1'b1);
      a_read(1, 4, 1'b1);
      tick();
      chk("a.rd0_bypass", ia.rd0_data, 8'h3C);
      chk("a.rd1_other", ia.rd1_data, 8'h00);
      a_write(6, 8'h00, 8'h0F, 1'b1);
      a_read(0, 6, 1'b1);
      a_read(1, 6, 1'b1);
      tick();
      tick();
      chk("a.rd0_hold", ia.rd0_data, 8'h30);
      chk("a.rd1_hold", ia.rd1_data, 8'h30);

      // Out-of-range on the 12-entry instance
      b_write(11, 8'h5A, 8'hFF);
      tick();
      b_read(0, 11);
      b_read(1, 0);
      tick();
      b_write(13, 8'h77, 8'hFF);
      b_read(0, 14);
      b_read(1, 12);
      tick();
      chk_bit("b.wr_err_oor", ib.wr_err, 1'b1);
      chk_bit("b.rd0_err_oor", ib.rd0_err, 1'b1);
      chk("b.rd0_data_oor", ib.rd0_data, 8'h00);
      tick();
      for (int i = 0; i < 12; i += 2) begin
         b_read(0, i);
         b_read(1, i + 1);
         tick();
      end

      // Clear request mid-operation; the request cycle's read is still serviced
      a_write(2, 8'hFF, 8'hFF, 1'b1);
      tick();
      ia.clear_req = 1'b1;
      a_read(0, 2, 1'b1);
      tick();
      for (int i = 0; i < 16; i++) ma[i] = 8'h00;
      for (int j = 1; j <= 16; j++) begin
         chk_bit("a.busy_creq", ia.busy, 1'b1);
         if (j == 1) a_write(2, 8'h11, 8'hFF, 1'b0);
         if (j == 3) ia.clear_req = 1'b1;
         if (j == 8) a_read(1, 2, 1'b0);
         tick();
      end
      chk_bit("a.busy_creq_done", ia.busy, 1'b0);
      a_read(0, 2, 1'b1);
      a_read(1, 3, 1'b1);
      tick();
      chk("a.rd0_cleared", ia.rd0_data, 8'h00);

      // Reset five cycles into a clear restarts it
      a_write(9, 8'h42, 8'hFF, 1'b1);
      tick();
      ia.clear_req = 1'b1;
      tick();
      repeat (5) begin
         chk_bit("a.busy_pre_rst", ia.busy, 1'b1);
         tick();
      end
      rst = 1'b1;
      tick();
      tick();
      chk_bit("a.busy_in_rst", ia.busy, 1'b1);
      chk_bit("b.busy_in_rst", ib.busy, 1'b1);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) ma[i] = 8'h00;
      for (int i = 0; i < 12; i++) mb[i] = 8'h00;
      for (int k = 1; k <= 16; k++) begin
         chk_bit("a.busy_restart", ia.busy, 1'b1);
         chk_bit("b.busy_restart", ib.busy, (k <= 12));
         tick();
      end
      chk_bit("a.busy_restart_done", ia.busy, 1'b0);
      a_read(0, 9, 1'b1);
      a_read(1, 15, 1'b1);
      b_read(0, 11);
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
